// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_t : fetch FSM encoding (RUN / HALTED)
//   IFU_ADDR_W    : default instruction memory address width (word addressed)
//   IFU_INSTR_W   : default instruction width
//   HALT_WORD     : word value that marks unprogrammed memory
package instr_fetch_unit_pkg;

  localparam int IFU_ADDR_W  = 5;
  localparam int IFU_INSTR_W = 32;

  localparam logic [IFU_INSTR_W-1:0] HALT_WORD = '0;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the program counter, drives the address of a
// combinational instruction memory and captures the returned word into a
// registered valid/ready stage feeding decode. Supports branch redirect,
// back-pressure and halting on an all-zero (unprogrammed) word.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   imem_addr       address to instruction memory (always the PC)
//   imem_instr      combinational read data for imem_addr
//   redirect_valid  load redirect_pc as the new PC (branch/jump/restart)
//   redirect_pc     redirect target
//   out_valid       out_instr/out_pc hold a word for decode
//   out_ready       decode accepts the word this cycle
//   out_instr       fetched instruction
//   out_pc          address the instruction came from
//   halted          fetch FSM is in HALTED
//   fetch_count     words delivered to the out stage, saturating
//
// State  | meaning
// RUN    | fetching one word per cycle when the out stage can take it
// HALTED | zero word seen; PC frozen, no fetch until a redirect
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                 ADDR_W       = IFU_ADDR_W,
  parameter int                 INSTR_W      = IFU_INSTR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC     = '0,
  parameter bit                 HALT_ON_ZERO = 1'b1,
  parameter int                 CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  opc_q, opc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               can_fetch;
  logic               is_halt_word;

  assign imem_addr   = pc_q;
  assign out_valid   = valid_q;
  assign out_instr   = instr_q;
  assign out_pc      = opc_q;
  assign halted      = (state_q == HALTED);
  assign fetch_count = cnt_q;

  // A new word may enter the out stage when the held one leaves this cycle.
  assign can_fetch    = (state_q == RUN) && (!valid_q || out_ready);
  assign is_halt_word = HALT_ON_ZERO && (imem_instr == INSTR_W'(HALT_WORD));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    cnt_d   = cnt_q;
    if (redirect_valid) begin
      // Any held word is discarded; the memory word read this cycle is ignored.
      state_d = RUN;
      pc_d    = redirect_pc;
      valid_d = 1'b0;
    end else if (can_fetch) begin
      if (is_halt_word) begin
        state_d = HALTED;
        valid_d = 1'b0;
      end else begin
        instr_d = imem_instr;
        opc_d   = pc_q;
        valid_d = 1'b1;
        pc_d    = pc_q + 1'b1;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end else if (valid_q && out_ready) begin
      // Only reachable in HALTED, where out_valid is already low; kept for safety.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      opc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
